// File: rtl/counters_pkg.sv
// Shared constants for the counters library: count direction and boundary mode encodings.
package counters_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: tick is combinational, high once per (prescale+1) enabled cycles.
// No backpressure; en=0 freezes the count, clr restarts the period from zero.
module tick_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  // A prescale lowered below pcnt lets pcnt roll over at full width before matching again.
  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (clr || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with wrap/saturate, sync clear/load and prescaled enable.
// Q and wrap are registered (one edge after a tick); tc is combinational; no backpressure.
module mod_updown_counter
  import counters_pkg::*;
#(
  parameter int N          = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sync_clr,
  input  logic                  load,
  input  logic [N-1:0]          load_val,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  sat_mode,
  input  logic [N-1:0]          mod_max,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [N-1:0]          Q,
  output logic                  tc,
  output logic                  wrap
);

  localparam logic [N-1:0] ONE = N'(1);

  logic         tick;
  logic [N-1:0] q_next;
  logic         wrap_next;

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (sync_clr | load),
    .en       (en),
    .prescale (prescale),
    .tick     (tick)
  );

  assign tc = (up_dn == CNT_UP) ? (Q >= mod_max) : (Q == '0);

  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    if (sync_clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = load_val;
    end else if (tick) begin
      if (up_dn == CNT_UP) begin
        if (Q < mod_max) begin
          q_next = Q + ONE;
        end else if (sat_mode == MODE_SAT) begin
          q_next = mod_max;
        end else begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (Q == '0) begin
          if (sat_mode == MODE_SAT) begin
            q_next = '0;
          end else begin
            q_next    = mod_max;
            wrap_next = 1'b1;
          end
        end else if (Q > mod_max) begin
          // An out-of-range loaded value re-enters the range silently when counting down.
          q_next = mod_max;
        end else begin
          q_next = Q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else begin
      Q    <= q_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: stimulus pushes model predictions, a monitor pops and compares.
module tb_mod_updown_counter;
  import counters_pkg::*;

  localparam int N  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sync_clr, load, en, up_dn, sat_mode;
  logic [N-1:0]  load_val, mod_max;
  logic [PW-1:0] prescale;
  logic [N-1:0]  Q;
  logic          tc, wrap;

  mod_updown_counter #(.N(N), .PRESCALE_W(PW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sync_clr (sync_clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
    .mod_max  (mod_max),
    .prescale (prescale),
    .Q        (Q),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int w;
    int tc;
    int id;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_item = 0;
  int   m_q    = 0;  // model count
  int   m_p    = 0;  // model prescaler position

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s item %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask

  // One clock of stimulus: apply inputs at the falling edge and predict the post-edge outputs.
  task automatic cyc(input bit clr, input bit ld, input int lv, input bit e,
                     input bit ud, input bit sm, input int mm, input int ps);
    exp_t x;
    int   w;
    bit   tk;
    lv = lv % (1 << N);
    mm = mm % (1 << N);
    ps = ps % (1 << PW);
    @(negedge clk);
    sync_clr = clr;
    load     = ld;
    load_val = lv[N-1:0];
    en       = e;
    up_dn    = ud;
    sat_mode = sm;
    mod_max  = mm[N-1:0];
    prescale = ps[PW-1:0];
    w = 0;
    if (clr) begin
      m_q = 0;
      m_p = 0;
    end else if (ld) begin
      m_q = lv;
      m_p = 0;
    end else begin
      tk = e && (m_p == ps);
      if (e) m_p = tk ? 0 : (m_p + 1) % (1 << PW);
      if (tk) begin
        if (ud) begin
          if (m_q < mm) m_q = m_q + 1;
          else if (sm) m_q = mm;
          else begin m_q = 0; w = 1; end
        end else begin
          if (m_q == 0) begin
            if (!sm) begin m_q = mm; w = 1; end
          end else if (m_q > mm) m_q = mm;
          else m_q = m_q - 1;
        end
      end
    end
    x.q  = m_q;
    x.w  = w;
    x.tc = ud ? int'(m_q >= mm) : int'(m_q == 0);
    x.id = n_item++;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("q",    x.id, 32'(Q),    32'(x.q));
        check("wrap", x.id, 32'(wrap), 32'(x.w));
        check("tc",   x.id, 32'(tc),   32'(x.tc));
      end
    end
  end

  initial begin : stimulus
    int mm, ps, dn;
    bit ud, sm;
    reset_n  = 1'b0;
    sync_clr = 1'b0;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;
    up_dn    = CNT_UP;
    sat_mode = MODE_WRAP;
    mod_max  = '0;
    prescale = '0;
    #12;
    check("reset_q",    -1, 32'(Q),    32'd0);
    check("reset_wrap", -1, 32'(wrap), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full-range up count in wrap mode.
    repeat (20) cyc(0, 0, 0, 1, CNT_UP, MODE_WRAP, 15, 0);
    // Modulo-10 up count, then down from zero wraps to mod_max.
    cyc(1, 0, 0, 1, CNT_UP, MODE_WRAP, 9, 0);
    repeat (22) cyc(0, 0, 0, 1, CNT_UP, MODE_WRAP, 9, 0);
    cyc(1, 0, 0, 1, CNT_UP, MODE_WRAP, 9, 0);
    repeat (3) cyc(0, 0, 0, 1, CNT_DOWN, MODE_WRAP, 9, 0);
    // Saturation both ways.
    cyc(1, 0, 0, 1, CNT_UP, MODE_SAT, 5, 0);
    repeat (8) cyc(0, 0, 0, 1, CNT_UP, MODE_SAT, 5, 0);
    repeat (8) cyc(0, 0, 0, 1, CNT_DOWN, MODE_SAT, 5, 0);
    // Prescaler with an enable gap mid-period.
    cyc(1, 0, 0, 1, CNT_UP, MODE_WRAP, 15, 3);
    repeat (10) cyc(0, 0, 0, 1, CNT_UP, MODE_WRAP, 15, 3);
    repeat (2)  cyc(0, 0, 0, 0, CNT_UP, MODE_WRAP, 15, 3);
    repeat (10) cyc(0, 0, 0, 1, CNT_UP, MODE_WRAP, 15, 3);
    // Out-of-range load, both directions, and clear-over-load priority.
    cyc(0, 1, 12, 1, CNT_UP, MODE_WRAP, 9, 0);
    repeat (2) cyc(0, 0, 0, 1, CNT_UP, MODE_WRAP, 9, 0);
    cyc(0, 1, 12, 1, CNT_DOWN, MODE_WRAP, 9, 0);
    repeat (2) cyc(0, 0, 0, 1, CNT_DOWN, MODE_WRAP, 9, 0);
    cyc(1, 1, 12, 1, CNT_UP, MODE_WRAP, 9, 0);
    // mod_max = 0 in both modes.
    repeat (4) cyc(0, 0, 0, 1, CNT_UP, MODE_WRAP, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, CNT_DOWN, MODE_SAT, 0, 0);
    // Async reset between edges at Q=7, then resume counting.
    cyc(1, 0, 0, 1, CNT_UP, MODE_WRAP, 15, 0);
    repeat (7) cyc(0, 0, 0, 1, CNT_UP, MODE_WRAP, 15, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_q",    -2, 32'(Q),    32'd0);
    check("async_rst_wrap", -2, 32'(wrap), 32'd0);
    m_q = 0;
    m_p = 0;
    #5;
    reset_n = 1'b1;
    repeat (3) cyc(0, 0, 0, 1, CNT_UP, MODE_WRAP, 15, 0);

    // Randomised traffic with slowly drifting configuration.
    mm = 9; ps = 0; ud = CNT_UP; sm = MODE_WRAP;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mm = $urandom_range(0, 15);
      if ($urandom_range(0, 9)  == 0) ud = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) sm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) ps = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 15),
          $urandom_range(0, 9) != 0, ud, sm, mm, ps);
    end

    dn = 0;
    while (sb.size() > 0 && dn < 10) begin
      @(posedge clk);
      #2;
      dn++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
